// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART byte transmitter between NUM_REQ byte-wise packet sources.
//   Round-robin arbitration, grant locked for a whole packet, optional
//   requester-ID header byte, idle-timeout release of a stalled owner, and a
//   bounded wait for the UART engine to acknowledge each start pulse.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   req_valid/data/   per-requester byte stream (byte i at req_data[8i+7:8i]),
//   req_last          last flag sampled with the accepted byte
//   req_ready         combinational accept strobe, only ever high for the owner
//   grant, active_id  one-hot owner and its index (registered)
//   uart_data/start   byte and one-cycle start pulse to the TX engine (registered)
//   uart_busy         TX engine busy flag
//   pkt_abort         one-cycle pulse when a stalled packet is released
module uart_tx_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter bit         ID_HEADER    = 1'b1,
  parameter logic [7:0] HEADER_BASE  = 8'hA0,
  parameter int         IDLE_TIMEOUT = 16,
  parameter int         ACK_TIMEOUT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [1:0]           active_id,
  output logic [7:0]           uart_data,
  output logic                 uart_start,
  input  logic                 uart_busy,
  output logic                 pkt_abort
);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {sIdle, sHeader, sData, sWaitHi, sWaitLo} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         id_q, id_d, last_id_q, last_id_d;
  logic [7:0]         data_q, data_d;
  logic               start_q, start_d, abort_q, abort_d;
  logic               last_flag_q, last_flag_d;
  logic [IW-1:0]      idle_cnt_q, idle_cnt_d;
  logic [AW-1:0]      ack_cnt_q, ack_cnt_d;

  logic               found;
  logic [1:0]         winner;
  logic               sel_valid, sel_last;
  logic [7:0]         sel_data;
  logic               accept, idle_expire, ack_expire;

  // Round-robin pick: scan last_id+1, last_id+2, ... and take the first valid.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (((int'(last_id_q) + k) % NUM_REQ) == i)) begin
          found  = 1'b1;
          winner = 2'(i);
        end
      end
    end
  end

  // Owner's request lane.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (id_q == 2'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  assign accept      = (state_q == sData) && sel_valid && !uart_busy;
  assign idle_expire = !sel_valid && (idle_cnt_q == IW'(IDLE_TIMEOUT - 1));
  assign ack_expire  = (ack_cnt_q == AW'(ACK_TIMEOUT - 1));

  // State register (and the registered datapath that follows the FSM).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= sIdle;
      grant_q     <= '0;
      id_q        <= '0;
      last_id_q   <= 2'(NUM_REQ - 1);
      data_q      <= '0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      last_flag_q <= 1'b0;
      idle_cnt_q  <= '0;
      ack_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      id_q        <= id_d;
      last_id_q   <= last_id_d;
      data_q      <= data_d;
      start_q     <= start_d;
      abort_q     <= abort_d;
      last_flag_q <= last_flag_d;
      idle_cnt_q  <= idle_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      sIdle:   if (found) state_d = ID_HEADER ? sHeader : sData;
      sHeader: if (!uart_busy) state_d = sWaitHi;
      sData: begin
        if (accept)           state_d = sWaitHi;
        else if (idle_expire) state_d = sIdle;
      end
      // A missing busy acknowledge is treated as a completed byte.
      sWaitHi: begin
        if (uart_busy)       state_d = sWaitLo;
        else if (ack_expire) state_d = last_flag_q ? sIdle : sData;
      end
      sWaitLo: if (!uart_busy) state_d = last_flag_q ? sIdle : sData;
      default: state_d = sIdle;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    grant_d     = grant_q;
    id_d        = id_q;
    last_id_d   = last_id_q;
    data_d      = data_q;
    start_d     = 1'b0;
    abort_d     = 1'b0;
    last_flag_d = last_flag_q;
    idle_cnt_d  = idle_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = (state_q == sData) && grant_q[i] && !uart_busy;
    case (state_q)
      sIdle: begin
        if (found) begin
          for (int i = 0; i < NUM_REQ; i++) grant_d[i] = (winner == 2'(i));
          id_d       = winner;
          last_id_d  = winner;
          idle_cnt_d = '0;
        end
      end
      sHeader: begin
        if (!uart_busy) begin
          data_d      = HEADER_BASE | {6'b0, id_q};
          start_d     = 1'b1;
          last_flag_d = 1'b0;
          ack_cnt_d   = '0;
        end
      end
      sData: begin
        if (accept) begin
          data_d      = sel_data;
          start_d     = 1'b1;
          last_flag_d = sel_last;
          idle_cnt_d  = '0;
          ack_cnt_d   = '0;
        end else if (sel_valid) begin
          idle_cnt_d = '0;
        end else if (idle_expire) begin
          abort_d    = 1'b1;
          grant_d    = '0;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      sWaitHi: begin
        if (!uart_busy) begin
          if (ack_expire) begin
            if (last_flag_q) grant_d = '0;
          end else begin
            ack_cnt_d = ack_cnt_q + AW'(1);
          end
        end
      end
      sWaitLo: if (!uart_busy && last_flag_q) grant_d = '0;
      default: ;
    endcase
  end

  assign grant      = grant_q;
  assign active_id  = id_q;
  assign uart_data  = data_q;
  assign uart_start = start_q;
  assign pkt_abort  = abort_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART byte transmitter between up to 4 requesters, each sending byte-wise packets. Round-robin arbitration; the grant is locked for the whole packet (until the byte flagged last is accepted). Optionally prefixes each packet with a requester-ID header byte. Releases a stalled requester after an idle timeout. Sits between the application sources and the UART TX byte engine (start pulse in, busy flag out).

Parameters:
NUM_REQ, 4, number of requesters, legal range 2..4; ID fields are 2 bits wide.
ID_HEADER, 1, 1 = send header byte HEADER_BASE|id before each packet; 0 = no header.
HEADER_BASE, 8'hA0, header byte base; bits [1:0] must be 0.
IDLE_TIMEOUT, 16, consecutive cycles with granted req_valid low in sData before the packet is aborted.
ACK_TIMEOUT, 4, cycles to wait for uart_busy to rise after uart_start before treating the byte as sent.

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  byte is the last of its packet; sampled with the accepted byte
req_ready  out  NUM_REQ  byte accepted this cycle (combinational)
grant  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle
active_id  out  2  index of the granted requester; valid while grant is nonzero
uart_data  out  8  byte to the UART TX engine (registered)
uart_start  out  1  one-cycle start pulse to the UART TX engine (registered)
uart_busy  in  1  UART TX engine is transmitting
pkt_abort  out  1  one-cycle pulse when a packet is released by timeout

Behaviour:
- Async reset clears all registered outputs to 0:
  - grant=0, active_id=0, uart_data=0, uart_start=0, pkt_abort=0.
  - State=sIdle, last_id=NUM_REQ-1, counters=0.
  - Reset mid-packet drops the packet silently; no abort pulse.
- Byte handshake: a byte transfers on a rising clk edge where req_valid[i] && req_ready[i].
  - req_ready[i] = (state==sData) && grant[i] && !uart_busy.
  - req_ready is never high for a non-granted requester.
- States:
  - sIdle: if any req_valid, pick the winner by round-robin. Priority order is last_id+1, last_id+2, ... mod NUM_REQ.
    - Set grant, active_id and last_id=winner.
    - Next state is sHeader if ID_HEADER=1, else sData.
    - The winner is decided in the same cycle the request is seen; grant is visible 1 cycle later.
  - sHeader: when !uart_busy, load uart_data=HEADER_BASE|active_id, pulse uart_start, go sWaitHi with ret=sData.
  - sData: on byte accept, load uart_data=byte, pulse uart_start, latch the last flag, clear the idle counter, go sWaitHi.
    - Each cycle with the granted req_valid low, the idle counter increments.
    - When the counter reaches IDLE_TIMEOUT: pulse pkt_abort, clear grant, go sIdle.
  - sWaitHi: wait for uart_busy=1, then go sWaitLo. After ACK_TIMEOUT cycles without busy, act as if busy rose and fell.
  - sWaitLo: wait for uart_busy=0.
    - If the latched last flag=1: clear grant, go sIdle.
    - Otherwise return to sData (after a data byte) or to sData (after the header).
- Latency:
  - uart_start rises 1 cycle after an accept (or after header load).
  - Minimum gap between starts = 1 + busy duration + 1 cycles.
- At most one byte is in flight; req_ready is low in sHeader, sWaitHi and sWaitLo.
- Simultaneous events:
  - A request from another requester during a locked packet is ignored until release.
  - A requester deasserting valid before grant loses the arbitration only if it is still low in sIdle.
  - If accept and timeout coincide, the accept wins and the counter clears.
- The grant returns to sIdle for at least 1 cycle between packets, so the same requester may win back-to-back only if no other requester is valid.
- uart_data holds its value between starts.

Test Plan:
- Single packet, ID_HEADER=1: req0 sends 8'h11, 8'h22 (last); busy model = 10 cycles -> uart sees A0, 11, 22 with 3 start pulses; grant0 drops after the last busy falls; pkt_abort=0.
- All 4 requesters valid from reset, 1-byte packets -> grant order 0, 1, 2, 3, 0; headers A0, A1, A2, A3.
- Packet lock: req1 owns a 3-byte packet while req2 asserts valid -> req2 gets no req_ready until req1's last byte completes; req2 is granted next.
- Stall timeout: req3 sends 1 non-last byte, then valid=0 for 16 cycles -> pkt_abort pulses once, grant=0, req0 (if valid) is granted next.
- No-ack: uart_busy tied 0 -> each byte advances after ACK_TIMEOUT=4 wait cycles; the packet completes normally.
- Reset mid-packet: assert reset during sWaitLo -> all outputs 0 immediately; after release, req0 is first priority.
